// File: rtl/gelato_operand_collector.sv
// Operand collector: latches one issued instruction, reads up to three source
// registers through a single-port vector RF (one read per cycle), then presents
// the instruction and assembled operands to execute over valid/ready.
module gelato_operand_collector #(
  parameter int unsigned INST_W     = 64,
  parameter int unsigned THREAD_NUM = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned WARP_W     = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [INST_W-1:0]            issue_inst,
  input  logic [WARP_W-1:0]            issue_warp_id,
  input  logic [REG_W-1:0]             issue_rs1,
  input  logic [REG_W-1:0]             issue_rs2,
  input  logic [REG_W-1:0]             issue_rs3,
  input  logic [2:0]                   issue_src_mask,
  output logic                         rf_rd_en,
  output logic [WARP_W-1:0]            rf_rd_warp,
  output logic [REG_W-1:0]             rf_rd_addr,
  input  logic [THREAD_NUM*DATA_W-1:0] rf_rd_data,
  output logic                         exec_valid,
  input  logic                         exec_ready,
  output logic [INST_W-1:0]            exec_inst,
  output logic [THREAD_NUM*DATA_W-1:0] exec_src1,
  output logic [THREAD_NUM*DATA_W-1:0] exec_src2,
  output logic [THREAD_NUM*DATA_W-1:0] exec_src3,
  output logic                         busy
);

  localparam int unsigned OP_W = THREAD_NUM * DATA_W;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [2:0]          rem_q, rem_d;         // sources still to be read
  logic [2:0]          rd_slot_q, rd_slot_d; // slot of the read on the RF port now
  logic [2:0]          pend_q, pend_d;       // slot whose data arrives this cycle
  logic [WARP_W-1:0]   warp_q, warp_d;
  logic [REG_W-1:0]    rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic                issue_ready_q, issue_ready_d;
  logic                rf_rd_en_q, rf_rd_en_d;
  logic [WARP_W-1:0]   rf_rd_warp_q, rf_rd_warp_d;
  logic [REG_W-1:0]    rf_rd_addr_q, rf_rd_addr_d;
  logic                exec_valid_q, exec_valid_d;
  logic                busy_q, busy_d;
  logic [INST_W-1:0]   exec_inst_q, exec_inst_d;
  logic [OP_W-1:0]     src1_q, src1_d, src2_q, src2_d, src3_q, src3_d;

  logic                accept;
  logic [2:0]          eff_mask;
  logic [2:0]          pick_mask;
  logic [2:0]          pick_slot;
  logic [REG_W-1:0]    pick_addr;
  logic [REG_W-1:0]    sel_rs1, sel_rs2, sel_rs3;

  assign accept   = issue_valid && issue_ready_q;
  // r0 reads as zero, so it never costs an RF access
  assign eff_mask = issue_src_mask & {issue_rs3 != '0, issue_rs2 != '0, issue_rs1 != '0};

  // Select the lowest remaining source, from the issue bus on accept or the latched copy later
  always_comb begin
    sel_rs1   = (state_q == IDLE) ? issue_rs1 : rs1_q;
    sel_rs2   = (state_q == IDLE) ? issue_rs2 : rs2_q;
    sel_rs3   = (state_q == IDLE) ? issue_rs3 : rs3_q;
    pick_mask = (state_q == IDLE) ? eff_mask  : rem_q;
    pick_slot = 3'b000;
    pick_addr = '0;
    if (pick_mask[0]) begin
      pick_slot = 3'b001;
      pick_addr = sel_rs1;
    end else if (pick_mask[1]) begin
      pick_slot = 3'b010;
      pick_addr = sel_rs2;
    end else if (pick_mask[2]) begin
      pick_slot = 3'b100;
      pick_addr = sel_rs3;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    rd_slot_d    = 3'b000;
    pend_d       = rf_rd_en_q ? rd_slot_q : 3'b000;
    warp_d       = warp_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rs3_d        = rs3_q;
    rf_rd_en_d   = 1'b0;
    rf_rd_warp_d = rf_rd_warp_q;
    rf_rd_addr_d = rf_rd_addr_q;
    exec_inst_d  = exec_inst_q;
    src1_d       = src1_q;
    src2_d       = src2_q;
    src3_d       = src3_q;

    // RF data lands one cycle after its strobe; steer it into the tagged slot
    if (pend_q[0]) src1_d = rf_rd_data;
    if (pend_q[1]) src2_d = rf_rd_data;
    if (pend_q[2]) src3_d = rf_rd_data;

    case (state_q)
      IDLE: begin
        if (accept) begin
          exec_inst_d = issue_inst;
          warp_d      = issue_warp_id;
          rs1_d       = issue_rs1;
          rs2_d       = issue_rs2;
          rs3_d       = issue_rs3;
          src1_d      = '0;
          src2_d      = '0;
          src3_d      = '0;
          if (eff_mask != 3'b000) begin
            rf_rd_en_d   = 1'b1;
            rf_rd_warp_d = issue_warp_id;
            rf_rd_addr_d = pick_addr;
            rd_slot_d    = pick_slot;
            rem_d        = eff_mask & ~pick_slot;
            state_d      = READ;
          end else begin
            rem_d   = 3'b000;
            state_d = DONE;
          end
        end
      end
      READ: begin
        if (rem_q != 3'b000) begin
          rf_rd_en_d   = 1'b1;
          rf_rd_warp_d = warp_q;
          rf_rd_addr_d = pick_addr;
          rd_slot_d    = pick_slot;
          rem_d        = rem_q & ~pick_slot;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (exec_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    issue_ready_d = (state_d == IDLE);
    exec_valid_d  = (state_d == DONE);
    busy_d        = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rem_q         <= 3'b000;
      rd_slot_q     <= 3'b000;
      pend_q        <= 3'b000;
      warp_q        <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rs3_q         <= '0;
      issue_ready_q <= 1'b1;
      rf_rd_en_q    <= 1'b0;
      rf_rd_warp_q  <= '0;
      rf_rd_addr_q  <= '0;
      exec_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      exec_inst_q   <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      src3_q        <= '0;
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      rd_slot_q     <= rd_slot_d;
      pend_q        <= pend_d;
      warp_q        <= warp_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rs3_q         <= rs3_d;
      issue_ready_q <= issue_ready_d;
      rf_rd_en_q    <= rf_rd_en_d;
      rf_rd_warp_q  <= rf_rd_warp_d;
      rf_rd_addr_q  <= rf_rd_addr_d;
      exec_valid_q  <= exec_valid_d;
      busy_q        <= busy_d;
      exec_inst_q   <= exec_inst_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      src3_q        <= src3_d;
    end
  end

  assign issue_ready = issue_ready_q;
  assign rf_rd_en    = rf_rd_en_q;
  assign rf_rd_warp  = rf_rd_warp_q;
  assign rf_rd_addr  = rf_rd_addr_q;
  assign exec_valid  = exec_valid_q;
  assign busy        = busy_q;
  assign exec_inst   = exec_inst_q;
  assign exec_src1   = src1_q;
  assign exec_src2   = src2_q;
  assign exec_src3   = src3_q;

endmodule

// File: doc/gelato_operand_collector.md
Name: gelato_operand_collector

Overview:
- Sits between warp issue and the execute unit.
- Accepts one issued instruction with up to three source register indices and reads each needed source from a single-read-port vector register file, one read per cycle.
- Presents the instruction plus three assembled warp-wide operands to the execute unit over a valid/ready handshake.
- Holds one instruction at a time. No overlap between collection and presentation.

Parameters:
- INST_W, 64: width of the opaque instruction word, passed through unmodified.
- THREAD_NUM, 32: threads per warp, i.e. lanes per operand.
- DATA_W, 32: bits per lane.
- REG_W, 5: register index width.
- WARP_W, 5: warp id width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  issue request
- issue_ready  out  1  collector can accept
- issue_inst  in  INST_W  instruction word
- issue_warp_id  in  WARP_W  owning warp
- issue_rs1, issue_rs2, issue_rs3  in  REG_W each  source indices
- issue_src_mask  in  3  bit i-1 set means source i is needed
- rf_rd_en  out  1  register file read strobe
- rf_rd_warp  out  WARP_W  read warp
- rf_rd_addr  out  REG_W  read index
- rf_rd_data  in  THREAD_NUM*DATA_W  read data, valid exactly one cycle after rf_rd_en
- exec_valid  out  1  operands ready
- exec_ready  in  1  execute unit accepts
- exec_inst  out  INST_W  latched instruction
- exec_src1, exec_src2, exec_src3  out  THREAD_NUM*DATA_W each  operands
- busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous, active-low. Reset forces:
  - state IDLE;
  - issue_ready=1, rf_rd_en=0, exec_valid=0, busy=0;
  - exec_inst, exec_src1..3, rf_rd_addr, rf_rd_warp all 0;
  - pending-read tag cleared.
- Reset mid-operation: the in-flight instruction is dropped. rf_rd_data returning after reset release is ignored.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - issue_ready=1.
  - On issue_valid, latch inst, warp id, indices and an effective mask. The effective mask is issue_src_mask with any bit cleared whose index is 0, because r0 reads as zero with no RF access.
  - Clear all three src registers to zero.
  - Next state: READ if the effective mask is nonzero, else DONE.
- READ:
  - Each cycle, drive rf_rd_en=1 for the lowest remaining needed source (order src1, src2, src3). Set rf_rd_warp and rf_rd_addr accordingly.
  - Clear that bit from the remaining mask and record the slot in the pending tag.
  - Data for the read issued in cycle N is captured into its slot at the end of cycle N+1.
  - When the last read is issued, go to DRAIN.
- DRAIN: rf_rd_en=0. Capture the final read data, then go to DONE.
- DONE:
  - exec_valid=1.
  - exec_inst and exec_src1..3 are held stable while exec_valid && !exec_ready.
  - On exec_ready, go to IDLE. issue_ready rises the following cycle, giving a one-cycle bubble.
- Latency: with the issue handshake at cycle T and k effective reads, exec_valid first asserts in cycle T+k+2 for k>=1, and in cycle T+1 for k=0.
- Sources not needed, or r0 sources, present all-zero lanes.
- exec_ready is ignored when exec_valid=0. issue_valid is ignored when issue_ready=0.
- rf_rd_en is never asserted outside READ. At most one read is outstanding at a time.
- A duplicate index (e.g. rs1==rs2) is read twice. No read merging.

Test Plan:
- Three sources: issue inst=0x1234, rs1=3, rs2=7, rs3=9, mask=3'b111, warp=2, at cycle T.
  - Required: rf_rd_addr 3,7,9 in T+1..T+3, each with warp 2.
  - Required: exec_valid at T+5 with src1/src2/src3 equal to the RF model data for r3/r7/r9, and exec_inst=0x1234.
- No reads: mask=3'b000, and separately mask=3'b111 with rs1=rs2=rs3=0.
  - Required: rf_rd_en never asserted, exec_valid at T+1, all sources zero.
- Sparse mask: mask=3'b101, rs1=4, rs3=6.
  - Required: reads of r4 then r6 in T+1 and T+2, exec_valid at T+4, src2=0.
- Backpressure: hold exec_ready=0 for 5 cycles after exec_valid.
  - Required: outputs stable, issue_ready=0 and a new issue_valid not accepted.
  - Required: after exec_ready=1, issue_ready=1 exactly one cycle later.
- Reset mid-read: assert rst_n=0 in cycle T+2 of a 3-source read.
  - Required: outputs immediately at reset values.
  - Required: after release, a new 1-source issue completes correctly, with no stale data in any src slot.
- Back-to-back: 20 random instructions with random exec_ready.
  - Required: scoreboard matches every operand against the RF model.
  - Required: rf_rd_en is never active outside READ.
